ibex_dbus_arbiter: RTL and testbench

//  Shares one OBI-style data-memory port between two requesters: port 0 = core load/store unit,

---
 rtl/ibex_dbus_arb_pkg.sv | 16 +
 rtl/ibex_dbus_arb_id_fifo.sv | 54 +++++
 rtl/ibex_dbus_arbiter.sv | 109 ++++++++++
 tb/tb_ibex_dbus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ibex_dbus_arb_pkg.sv
// Shared types and constants for the Ibex data-bus arbiter.
// The optional IBEX_DBUS_ARB_RR_EN build is selected in ibex_dbus_arbiter.sv.
package ibex_dbus_arb_pkg;

  localparam int unsigned NUM_REQ               = 2;
  localparam int unsigned MAX_OUTSTANDING_LIMIT = 8;

  // Requester index carried through the response-routing FIFO.
  typedef logic arb_id_t;

  // Width of an index over n entries, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ibex_dbus_arb_id_fifo.sv
// Synchronous FIFO of requester IDs, used to route bus responses back in grant order.
// Pointers wrap modulo Depth, so non-power-of-two depths are supported.
module ibex_dbus_arb_id_fifo
  import ibex_dbus_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  logic    pop_i,
  input  arb_id_t wdata_i,
  output arb_id_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  arb_id_t           mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the occupancy count guarantees no entry is read before written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ibex_dbus_arbiter.sv
// Two-port OBI data-bus arbiter (LSU = port 0, secondary master = port 1) with in-order
// response routing. Define IBEX_DBUS_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module ibex_dbus_arbiter
  import ibex_dbus_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   rvalid_o,
  output logic [NUM_REQ-1:0]   err_o,
  input  logic [63:0]          addr_i,
  input  logic [NUM_REQ-1:0]   we_i,
  input  logic [7:0]           be_i,
  input  logic [63:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 bus_req_o,
  input  logic                 bus_gnt_i,
  input  logic                 bus_rvalid_i,
  input  logic                 bus_err_i,
  output logic [31:0]          bus_addr_o,
  output logic                 bus_we_o,
  output logic [3:0]           bus_be_o,
  output logic [31:0]          bus_wdata_o,
  input  logic [31:0]          bus_rdata_i,
  output logic                 unexp_rsp_o
);

  logic    lock_q, lock_d;
  arb_id_t lock_id_q;
  logic    lock_active;
  arb_id_t arb_winner, winner;
  logic    fifo_full, fifo_empty, push, pop;
  arb_id_t head_id;

`ifdef IBEX_DBUS_ARB_RR_EN
  arb_id_t rr_ptr_q;

  always_comb begin
    arb_winner = 1'b0;
    if (req_i == 2'b11) arb_winner = rr_ptr_q;
    else if (req_i[1])  arb_winner = 1'b1;
  end

  // Only free arbitration moves the pointer; a locked grant was already decided earlier.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                     rr_ptr_q <= 1'b0;
    else if (bus_req_o && bus_gnt_i && !lock_active) rr_ptr_q <= ~winner;
  end
`else
  assign arb_winner = ~req_i[0] & req_i[1];
`endif

  // A lock whose owner dropped its request is ignored so arbitration resumes this cycle.
  assign lock_active = lock_q & req_i[lock_id_q];
  assign winner      = lock_active ? lock_id_q : arb_winner;

  assign bus_req_o   = (|req_i) & ~fifo_full;
  assign bus_addr_o  = winner ? addr_i[63:32]  : addr_i[31:0];
  assign bus_we_o    = winner ? we_i[1]        : we_i[0];
  assign bus_be_o    = winner ? be_i[7:4]      : be_i[3:0];
  assign bus_wdata_o = winner ? wdata_i[63:32] : wdata_i[31:0];

  assign lock_d = bus_req_o & ~bus_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      if (lock_d) lock_id_q <= winner;
    end
  end

  assign push = bus_req_o & bus_gnt_i;
  assign pop  = bus_rvalid_i & ~fifo_empty;

  ibex_dbus_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (winner),
    .rdata_o (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    gnt_o[winner] = push;
    if (pop) begin
      rvalid_o[head_id] = 1'b1;
      err_o[head_id]    = bus_err_i;
    end
  end

  assign rdata_o     = bus_rdata_i;
  assign unexp_rsp_o = bus_rvalid_i & fifo_empty;

endmodule

// File: tb/tb_ibex_dbus_arbiter.sv
// Directed self-checking bench for ibex_dbus_arbiter (MaxOutstanding = 2).
// Expected arbitration order follows IBEX_DBUS_ARB_RR_EN when it is defined.
module tb_ibex_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, we = '0;
  logic [1:0]  gnt, rvalid, err;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  be = '0;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata = '0;
  logic        bus_req, bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic        bus_we, unexp;
  logic [3:0]  bus_be;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  ibex_dbus_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .err_o        (err),
    .addr_i       (addr),
    .we_i         (we),
    .be_i         (be),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .bus_req_o    (bus_req),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_err_i    (bus_err),
    .bus_addr_o   (bus_addr),
    .bus_we_o     (bus_we),
    .bus_be_o     (bus_be),
    .bus_wdata_o  (bus_wdata),
    .bus_rdata_i  (bus_rdata),
    .unexp_rsp_o  (unexp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic e);
    req = r; bus_gnt = g; bus_rvalid = rv; bus_err = e;
  endtask

  logic [1:0] exp_gnt [4];
  logic [1:0] exp_rv  [5];

  initial begin
`ifdef IBEX_DBUS_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_rv  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    addr  = {32'h300, 32'h100};
    wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    be    = 8'hC3;
    we    = 2'b10;

    // Reset state
    sample();
    check("rst_gnt", gnt, 2'b00);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_err", err, 2'b00);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_unexp", unexp, 1'b0);
    tick();
    rst_n = 1'b1;

    // 1: single LSU read, zero-latency request path and response routing
    tick(); drive(2'b01, 1'b1, 1'b0, 1'b0);
    sample();
    check("t1_addr", bus_addr, 32'h100);
    check("t1_gnt", gnt, 2'b01);
    check("t1_be", bus_be, 4'h3);
    check("t1_we", bus_we, 1'b0);
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0); bus_rdata = 32'hDEADBEEF;
    sample();
    check("t1_rvalid", rvalid, 2'b01);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_unexp", unexp, 1'b0);

    // 2: lock forms on port 1, held while port 0 also requests
    tick(); drive(2'b10, 1'b0, 1'b0, 1'b0);
    sample();
    check("t2_addr_first", bus_addr, 32'h300);
    check("t2_gnt_wait", gnt, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(2'b11, 1'b0, 1'b0, 1'b0);
      sample();
      check("t2_addr_locked", bus_addr, 32'h300);
      check("t2_wdata_locked", bus_wdata, 32'hBBBB_0001);
      check("t2_gnt_locked", gnt, 2'b00);
    end
    tick(); drive(2'b11, 1'b1, 1'b0, 1'b0);
    sample();
    check("t2_gnt_owner", gnt, 2'b10);
    check("t2_we_owner", bus_we, 1'b1);
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b1);
    sample();
    check("t2_rvalid", rvalid, 2'b10);
    check("t2_err", err, 2'b10);

    // 3: two outstanding fill the FIFO; a response while full still blocks the request
    tick(); drive(2'b01, 1'b1, 1'b0, 1'b0);
    sample(); check("t3_gnt_a", gnt, 2'b01);
    tick();
    sample(); check("t3_gnt_b", gnt, 2'b01);
    tick(); drive(2'b01, 1'b1, 1'b1, 1'b0);
    sample();
    check("t3_full_req", bus_req, 1'b0);
    check("t3_full_gnt", gnt, 2'b00);
    check("t3_full_rvalid", rvalid, 2'b01);
    tick(); drive(2'b01, 1'b0, 1'b0, 1'b0);
    sample(); check("t3_req_back", bus_req, 1'b1);
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0);
    sample(); check("t3_drain", rvalid, 2'b01);

    // 5: response with an empty FIFO is dropped and flagged for one cycle
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0);
    sample();
    check("t5_unexp", unexp, 1'b1);
    check("t5_rvalid", rvalid, 2'b00);
    tick(); drive(2'b00, 1'b0, 1'b0, 1'b0);
    sample(); check("t5_unexp_clr", unexp, 1'b0);

    // 4: error routed to port 1, clean response to port 0, in grant order
    tick(); drive(2'b10, 1'b1, 1'b0, 1'b0);
    sample(); check("t4_gnt1", gnt, 2'b10);
    tick(); drive(2'b01, 1'b1, 1'b0, 1'b0);
    sample(); check("t4_gnt0", gnt, 2'b01);
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b1);
    sample();
    check("t4_rvalid1", rvalid, 2'b10);
    check("t4_err1", err, 2'b10);
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0);
    sample();
    check("t4_rvalid0", rvalid, 2'b01);
    check("t4_err0", err, 2'b00);

    // 6a: reset in the middle of a transfer clears FIFO, lock and pointer
    tick(); drive(2'b10, 1'b1, 1'b0, 1'b0);
    tick(); drive(2'b00, 1'b0, 1'b0, 1'b0); rst_n = 1'b0;
    sample();
    check("t6_rst_gnt", gnt, 2'b00);
    check("t6_rst_rvalid", rvalid, 2'b00);
    check("t6_rst_bus_req", bus_req, 1'b0);
    check("t6_rst_unexp", unexp, 1'b0);
    tick(); rst_n = 1'b1;
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0);
    sample();
    check("t6_stale_unexp", unexp, 1'b1);
    check("t6_stale_rvalid", rvalid, 2'b00);

    // 6b: both ports request every cycle with back-to-back responses
    for (int i = 0; i < 4; i++) begin
      tick(); drive(2'b11, 1'b1, (i != 0), 1'b0);
      sample();
      check($sformatf("t6_gnt%0d", i), gnt, exp_gnt[i]);
      check($sformatf("t6_rv%0d", i), rvalid, exp_rv[i]);
      check($sformatf("t6_req%0d", i), bus_req, 1'b1);
    end
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0);
    sample();
    check("t6_rv_last", rvalid, exp_rv[4]);
    check("t6_unexp_last", unexp, 1'b0);
    tick(); drive(2'b00, 1'b0, 1'b1, 1'b0);
    sample(); check("t6_empty_after", unexp, 1'b1);
    tick(); drive(2'b00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
